// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester holding FIFOs feed a registered CDB,
// granting the oldest pending result by ROB age relative to the ROB head.
module cdb_arbiter #(
    parameter  int N_REQ          = 3,
    parameter  int ROB_DEPTH_BITS = 4,
    parameter  int FIFO_DEPTH     = 2,
    localparam int SRC_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [ROB_DEPTH_BITS-1:0]       rob_head,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*ROB_DEPTH_BITS-1:0] req_tag,
    input  logic [N_REQ*32-1:0]             req_value,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            cdb_valid,
    output logic [ROB_DEPTH_BITS-1:0]       cdb_tag,
    output logic [31:0]                     cdb_value,
    output logic [SRC_W-1:0]                cdb_src
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef logic [ROB_DEPTH_BITS-1:0] tag_t;

    // Holding FIFO storage and bookkeeping, one set per requester.
    tag_t             fifo_tag   [N_REQ][FIFO_DEPTH];
    logic [31:0]      fifo_value [N_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr     [N_REQ];
    logic [PTR_W-1:0] rd_ptr     [N_REQ];
    logic [CNT_W-1:0] count      [N_REQ];

    tag_t             head_tag   [N_REQ];
    logic [31:0]      head_value [N_REQ];
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;

    logic             grant_valid;
    logic [SRC_W-1:0] grant_idx;

    // Handshake: ready comes only from the registered count, never from a same-cycle pop.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i]  = (count[i] < FULL_CNT) && !flush;
            push[i]       = req_valid[i] && req_ready[i];
            pop[i]        = grant_valid && !flush && (grant_idx == SRC_W'(i));
            head_tag[i]   = fifo_tag[i][rd_ptr[i]];
            head_value[i] = fifo_value[i][rd_ptr[i]];
        end
    end

    // Grant: minimum wrapped age among non-empty FIFOs; strict compare keeps lowest index on ties.
    always_comb begin
        tag_t age;
        tag_t best_age;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_age    = '0;
        age         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            age = head_tag[i] - rob_head;
            if (count[i] != '0 && (!grant_valid || age < best_age)) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(i);
                best_age    = age;
            end
        end
    end

    // FIFO data write; push is already blocked during flush.
    // NOTE: storage is not reset -- count gates every read, so contents before the first push never matter.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (push[i]) begin
                fifo_tag[i][wr_ptr[i]]   <= req_tag[i*ROB_DEPTH_BITS +: ROB_DEPTH_BITS];
                fifo_value[i][wr_ptr[i]] <= req_value[i*32 +: 32];
            end
        end
    end

    // FIFO pointers and counts; flush empties every FIFO with priority over push and pop.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Registered CDB: load the winner's head, or drop valid and hold the payload fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_valid) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head_tag[grant_idx];
            cdb_value <= head_value[grant_idx];
            cdb_src   <= grant_idx;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, age ordering with wrap,
// backpressure, flush and asynchronous reset mid-stream.
module tb_cdb_arbiter;

    localparam int N_REQ = 3;
    localparam int RB    = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [RB-1:0]    rob_head;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ*RB-1:0] req_tag;
    logic [N_REQ*32-1:0] req_value;
    logic [N_REQ-1:0] req_ready;
    logic             cdb_valid;
    logic [RB-1:0]    cdb_tag;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;

    int checks;
    int errors;

    cdb_arbiter #(.N_REQ(N_REQ), .ROB_DEPTH_BITS(RB), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rob_head  (rob_head),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [RB-1:0] t, input logic [31:0] val);
        req_valid[i]         = v;
        req_tag[i*RB +: RB]  = t;
        req_value[i*32 +: 32] = val;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_tag   = '0;
        req_value = '0;
    endtask

    task automatic expect_cdb(input string tag, input logic [RB-1:0] t, input logic [1:0] src);
        check({tag, "_valid"}, 32'(cdb_valid), 32'd1);
        check({tag, "_tag"},   32'(cdb_tag),   32'(t));
        check({tag, "_src"},   32'(cdb_src),   32'(src));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        rob_head = '0;
        clear_reqs();

        // 1. Reset then idle
        #1;
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_tag",   32'(cdb_tag),   32'd0);
        check("rst_value", cdb_value,      32'd0);
        check("rst_src",   32'(cdb_src),   32'd0);
        check("rst_ready", 32'(req_ready), 32'b111);
        repeat (2) begin
            tick();
            check("rst_hold_valid", 32'(cdb_valid), 32'd0);
            check("rst_hold_ready", 32'(req_ready), 32'b111);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(cdb_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'b111);

        // 2. Single ALU result, two-edge latency, one cycle wide
        rob_head = 4'd0;
        set_req(0, 1'b1, 4'd5, 32'hDEADBEEF);
        tick();
        clear_reqs();
        check("alu_lat1_valid", 32'(cdb_valid), 32'd0);
        tick();
        expect_cdb("alu", 4'd5, 2'd0);
        check("alu_value", cdb_value, 32'hDEADBEEF);
        tick();
        check("alu_once", 32'(cdb_valid), 32'd0);

        // 3. Age priority with wrap: head 14 -> MEM(15) age1, BRANCH(0) age2, ALU(2) age4
        rob_head = 4'd14;
        set_req(0, 1'b1, 4'd2,  32'hA0A0_0002);
        set_req(1, 1'b1, 4'd15, 32'hB1B1_000F);
        set_req(2, 1'b1, 4'd0,  32'hC2C2_0000);
        tick();
        clear_reqs();
        check("age_ready_after_push", 32'(req_ready), 32'b111);
        tick();
        expect_cdb("age_first", 4'd15, 2'd1);
        check("age_first_value", cdb_value, 32'hB1B1_000F);
        tick();
        expect_cdb("age_second", 4'd0, 2'd2);
        tick();
        expect_cdb("age_third", 4'd2, 2'd0);
        check("age_third_value", cdb_value, 32'hA0A0_0002);
        tick();
        check("age_drain", 32'(cdb_valid), 32'd0);

        // 4. Backpressure: MEM holds tags 3,4,5 while ALU supplies older 0,1,2
        rob_head = 4'd0;
        set_req(0, 1'b1, 4'd0, 32'd100);
        set_req(1, 1'b1, 4'd3, 32'd103);
        tick();                                   // both push
        check("bp_e0_valid", 32'(cdb_valid), 32'd0);
        set_req(0, 1'b1, 4'd1, 32'd101);
        set_req(1, 1'b1, 4'd4, 32'd104);
        tick();                                   // both push, ALU 0 granted
        expect_cdb("bp_t0", 4'd0, 2'd0);
        check("bp_mem_full1", 32'(req_ready[1]), 32'd0);
        set_req(0, 1'b1, 4'd2, 32'd102);
        set_req(1, 1'b1, 4'd5, 32'd105);
        tick();                                   // ALU pushes 2, MEM blocked, ALU 1 granted
        expect_cdb("bp_t1", 4'd1, 2'd0);
        check("bp_mem_full2", 32'(req_ready[1]), 32'd0);
        set_req(0, 1'b0, 4'd0, 32'd0);
        tick();                                   // ALU 2 granted
        expect_cdb("bp_t2", 4'd2, 2'd0);
        check("bp_mem_full3", 32'(req_ready[1]), 32'd0);
        tick();                                   // MEM 3 granted, MEM pops
        expect_cdb("bp_t3", 4'd3, 2'd1);
        check("bp_t3_value", cdb_value, 32'd103);
        check("bp_mem_ready", 32'(req_ready[1]), 32'd1);
        tick();                                   // MEM pushes 5, MEM 4 granted
        clear_reqs();
        expect_cdb("bp_t4", 4'd4, 2'd1);
        tick();
        expect_cdb("bp_t5", 4'd5, 2'd1);
        check("bp_t5_value", cdb_value, 32'd105);
        tick();
        check("bp_drain", 32'(cdb_valid), 32'd0);

        // 5. Flush: ALU tag 6 pending, tag 7 offered while flush is high
        set_req(0, 1'b1, 4'd6, 32'h0000_0006);
        tick();
        set_req(0, 1'b1, 4'd7, 32'h0000_0007);
        flush = 1'b1;
        #1;
        check("flush_ready_low", 32'(req_ready), 32'b000);
        tick();                                   // grant would occur here
        flush = 1'b0;
        clear_reqs();
        #1;
        check("flush_valid", 32'(cdb_valid), 32'd0);
        check("flush_tag_hold", 32'(cdb_tag), 32'd5);
        check("flush_ready_back", 32'(req_ready), 32'b111);
        repeat (3) begin
            tick();
            check("flush_no_stale", 32'(cdb_valid), 32'd0);
        end
        set_req(0, 1'b1, 4'd9, 32'h0000_0009);
        tick();
        clear_reqs();
        tick();
        expect_cdb("post_flush", 4'd9, 2'd0);
        check("post_flush_value", cdb_value, 32'h0000_0009);
        tick();
        check("post_flush_once", 32'(cdb_valid), 32'd0);

        // 6. Asynchronous reset while cdb_valid=1 with MEM data still pending
        set_req(0, 1'b1, 4'd10, 32'h0000_000A);
        set_req(1, 1'b1, 4'd11, 32'h0000_000B);
        tick();
        clear_reqs();
        tick();
        expect_cdb("pre_rst", 4'd10, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(cdb_valid), 32'd0);
        check("async_rst_tag",   32'(cdb_tag),   32'd0);
        check("async_rst_ready", 32'(req_ready), 32'b111);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("after_rst_no_stale", 32'(cdb_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional units (ALU, memory, branch) that complete out of order.
- Each requester pushes a completed result into a small per-requester holding FIFO.
- Each cycle the arbiter grants the oldest pending result, judged by ROB age relative to the ROB head, and drives it onto a registered CDB.
- The reservation stations and ROB consume that bus for wakeup and commit.

Parameters:
N_REQ, 3, number of requesting functional units (index 0 = ALU, 1 = MEM, 2 = BRANCH)
ROB_DEPTH_BITS, 4, ROB tag width (ROB depth = 2**ROB_DEPTH_BITS)
FIFO_DEPTH, 2, entries per requester holding FIFO (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  branch-mispredict flush; drop all pending and in-flight results
rob_head  input  ROB_DEPTH_BITS  tag of the oldest ROB entry, used for age calculation
req_valid  input  N_REQ  per-requester result valid
req_tag  input  N_REQ*ROB_DEPTH_BITS  per-requester ROB tag, packed with requester i at [i*ROB_DEPTH_BITS +: ROB_DEPTH_BITS]
req_value  input  N_REQ*32  per-requester result value, packed with requester i at [i*32 +: 32]
req_ready  output  N_REQ  per-requester FIFO can accept
cdb_valid  output  1  CDB broadcast valid
cdb_tag  output  ROB_DEPTH_BITS  broadcast ROB tag
cdb_value  output  32  broadcast value
cdb_src  output  $clog2(N_REQ)  index of the granted requester

Behaviour:
- Reset (asynchronous, rst_n low):
  - All FIFOs empty, pointers and counts zero.
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
  - req_ready all 1 as long as flush is low.
- Handshake:
  - A transfer on requester i occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
  - req_ready[i] is (count[i] < FIFO_DEPTH) and !flush.
  - req_ready is derived only from registered count. There is no pass-through: a full FIFO deasserts ready even if it pops the same cycle.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits, wrapping naturally.
  - count is $clog2(FIFO_DEPTH)+1 bits.
  - A simultaneous push and pop leaves count unchanged.
- Eligibility: requester i is eligible in a cycle iff count[i] > 0 (registered). Entries pushed at edge E become eligible in the cycle after E.
- Age: age_i = (head_tag_i - rob_head) mod 2**ROB_DEPTH_BITS, an unsigned ROB_DEPTH_BITS-bit subtraction with wrap.
- Grant:
  - The eligible requester with minimum age wins.
  - On an equal-age tie (which should not occur, since tags are unique), the lowest index wins.
  - Selection is combinational within the cycle.
- Output register, updated at each rising edge:
  - If flush: cdb_valid <= 0; other cdb fields hold.
  - Else if any eligible: cdb_valid <= 1, cdb_tag/value/src <= the winner's FIFO head, and the winner's FIFO is popped.
  - Else cdb_valid <= 0 and the other fields hold.
- Latency: a result accepted at edge E0 with no competition appears with cdb_valid=1 in the cycle following edge E0+1, i.e. 2 edges.
- Throughput: one broadcast per cycle maximum. Sustained back-to-back broadcasts are possible from one requester.
- Flush:
  - At a rising edge with flush=1, every FIFO is emptied (pointers and counts to 0), no push or pop occurs, and cdb_valid <= 0.
  - Flush has priority over simultaneous push, pop and grant.
- Reset mid-operation: asynchronous clear regardless of pending data. No partial broadcast survives.
- No stall input: the CDB is always consumed. Requesters stall themselves on req_ready=0.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles, no requests -> cdb_valid=0, req_ready=3'b111 throughout.
2. Single ALU result: rob_head=0, req_valid[0]=1 with tag=5, value=32'hDEADBEEF for one edge -> two edges later cdb_valid=1, cdb_tag=5, cdb_value=DEADBEEF, cdb_src=0 for exactly one cycle.
3. Age priority with wrap: rob_head=14; ALU tag=2 (age 4), MEM tag=15 (age 1), BRANCH tag=0 (age 2), all pushed the same edge -> broadcast order MEM(15), BRANCH(0), ALU(2) on three consecutive cycles, cdb_src 1, 2, 0.
4. Backpressure: hold req_valid[1]=1 with tags 3, 4, 5 while ALU floods older tags (rob_head=0, ALU tags 0, 1, 2) -> MEM FIFO fills after 2 pushes, req_ready[1]=0 until MEM wins. All six tags are broadcast exactly once in age order 0..5.
5. Flush: fill ALU FIFO with tags 6, 7 and assert flush on the edge a grant would occur -> cdb_valid=0 next cycle, tags 6/7 never broadcast, req_ready=1 the cycle after flush deasserts.
6. Async reset mid-stream: assert rst_n low between edges while cdb_valid=1 -> cdb_valid drops to 0 immediately (before the next edge). After release, no stale tag is broadcast.
